// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: FSM encodings, default sizes,
// and the helper that sizes the latency counter.
package mdu_pkg;

  localparam int unsigned WIDTH_DEF        = 32;
  localparam int unsigned MULT_LATENCY_DEF = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // A latency of 1 still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? int'($clog2(lat)) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(MULT_LATENCY_DEF);

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate: operand magnitude when W=WIDTH,
// product sign correction when W=2*WIDTH.
module mult_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] fixed_c
);

  assign fixed_c = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Issue/writeback controller for the unsigned multiplier array: forms operand
// magnitudes, waits a fixed latency, sign-corrects the product into HI/LO.
module mult_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int unsigned WIDTH        = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               mthi_we,
  input  logic               mtlo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_in1,
  output logic [WIDTH-1:0]   mul_in2,
  input  logic [2*WIDTH-1:0] mul_out
);

  localparam int unsigned     CNT_W    = cnt_width(MULT_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LATENCY - 1);

  logic [0:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               neg, neg_nxt;
  logic               done_nxt, start_nxt;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt, in1_nxt, in2_nxt;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [2*WIDTH-1:0] prod_c;

  mult_sign_fix #(.W(WIDTH)) u_mag_a (
    .value   (req_a),
    .negate  (req_signed & req_a[WIDTH-1]),
    .fixed_c (mag_a_c)
  );

  mult_sign_fix #(.W(WIDTH)) u_mag_b (
    .value   (req_b),
    .negate  (req_signed & req_b[WIDTH-1]),
    .fixed_c (mag_b_c)
  );

  // Negate across the full 64 bits so the LO borrow reaches HI.
  mult_sign_fix #(.W(2*WIDTH)) u_prod (
    .value   (mul_out),
    .negate  (neg),
    .fixed_c (prod_c)
  );

  assign busy = (state == RUN);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    neg_nxt   = neg;
    hi_nxt    = hi;
    lo_nxt    = lo;
    done_nxt  = 1'b0;
    start_nxt = mul_start;
    in1_nxt   = mul_in1;
    in2_nxt   = mul_in2;
    if (state == IDLE) begin
      // MT writes land now; an accepted product overwrites them later.
      if (mthi_we) hi_nxt = wdata;
      if (mtlo_we) lo_nxt = wdata;
      if (req_valid) begin
        in1_nxt   = mag_a_c;
        in2_nxt   = mag_b_c;
        neg_nxt   = req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
        start_nxt = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
      if (cnt == CNT_LAST) begin
        {hi_nxt, lo_nxt} = prod_c;
        start_nxt = 1'b0;
        done_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      neg       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      mul_start <= 1'b0;
      mul_in1   <= '0;
      mul_in2   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      neg       <= neg_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      done      <= done_nxt;
      mul_start <= start_nxt;
      mul_in1   <= in1_nxt;
      mul_in2   <= in2_nxt;
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural pipelined multiplier.
module tb_mult_hilo_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_signed, mthi_we, mtlo_we;
  logic [31:0] req_a, req_b, wdata;
  logic        busy, done, mul_start;
  logic [31:0] hi, lo, mul_in1, mul_in2;
  logic [63:0] mul_out;
  logic [63:0] pipe [0:LAT-2];

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  // Product must be settled before the DUT's sampling edge, LAT edges after accept.
  always @(posedge clk) begin
    pipe[0] <= {32'd0, mul_in1} * {32'd0, mul_in2};
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_out = pipe[LAT-2];

  mult_hilo_ctrl #(.MULT_LATENCY(LAT), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out)
  );

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_a = '0; req_b = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset hilo got %h want 0", {hi, lo}); end
    total++; if ({busy, done, mul_start} !== 3'b000) begin bad++; $display("FAIL reset ctl got %b want 000", {busy, done, mul_start}); end
    total++; if ({mul_in1, mul_in2} !== 64'd0) begin bad++; $display("FAIL reset in got %h want 0", {mul_in1, mul_in2}); end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult_vector(input string name, input logic sgn, input logic [31:0] a, b,
                                  input logic [31:0] e_in1, e_in2, e_hi, e_lo);
    @(negedge clk);
    req_valid = 1'b1; req_signed = sgn; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if ({busy, mul_start, done} !== 3'b110) begin bad++; $display("FAIL %s accept busy/start/done got %b want 110", name, {busy, mul_start, done}); end
    total++; if (mul_in1 !== e_in1) begin bad++; $display("FAIL %s mul_in1 got %h want %h", name, mul_in1, e_in1); end
    total++; if (mul_in2 !== e_in2) begin bad++; $display("FAIL %s mul_in2 got %h want %h", name, mul_in2, e_in2); end
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      total++; if ({busy, mul_start, done} !== 3'b110) begin bad++; $display("FAIL %s run%0d busy/start/done got %b want 110", name, i, {busy, mul_start, done}); end
      total++; if ({mul_in1, mul_in2, hi, lo} !== {e_in1, e_in2, m_hi, m_lo}) begin bad++; $display("FAIL %s run%0d in/hilo got %h want %h", name, i, {mul_in1, mul_in2, hi, lo}, {e_in1, e_in2, m_hi, m_lo}); end
    end
    @(negedge clk);
    total++; if ({busy, mul_start, done} !== 3'b001) begin bad++; $display("FAIL %s done busy/start/done got %b want 001", name, {busy, mul_start, done}); end
    total++; if (hi !== e_hi) begin bad++; $display("FAIL %s hi got %h want %h", name, hi, e_hi); end
    total++; if (lo !== e_lo) begin bad++; $display("FAIL %s lo got %h want %h", name, lo, e_lo); end
    m_hi = e_hi; m_lo = e_lo;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL %s after busy/done got %b want 00", name, {busy, done}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd2; req_b = 32'd3;
    @(negedge clk);
    req_a = 32'd7; req_b = 32'd6;
    total++; if ({mul_in1, mul_in2} !== {32'd2, 32'd3}) begin bad++; $display("FAIL b2b first in got %h want %h", {mul_in1, mul_in2}, {32'd2, 32'd3}); end
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      total++; if ({busy, done, mul_in1} !== {2'b10, 32'd2}) begin bad++; $display("FAIL b2b held%0d busy/done/in1 got %h want %h", i, {busy, done, mul_in1}, {2'b10, 32'd2}); end
    end
    @(negedge clk);
    total++; if ({busy, done, hi, lo} !== {2'b01, 32'd0, 32'd6}) begin bad++; $display("FAIL b2b first done got %h want %h", {busy, done, hi, lo}, {2'b01, 32'd0, 32'd6}); end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if ({busy, done, mul_in1, mul_in2} !== {2'b10, 32'd7, 32'd6}) begin bad++; $display("FAIL b2b second accept got %h want %h", {busy, done, mul_in1, mul_in2}, {2'b10, 32'd7, 32'd6}); end
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      total++; if ({busy, done, lo} !== {2'b10, 32'd6}) begin bad++; $display("FAIL b2b run%0d busy/done/lo got %h want %h", i, {busy, done, lo}, {2'b10, 32'd6}); end
    end
    @(negedge clk);
    total++; if ({busy, done, hi, lo} !== {2'b01, 32'd0, 32'd42}) begin bad++; $display("FAIL b2b second done got %h want %h", {busy, done, hi, lo}, {2'b01, 32'd0, 32'd42}); end
    m_hi = 32'd0; m_lo = 32'd42;
  endtask

  task automatic test_mt();
    @(negedge clk);
    mtlo_we = 1'b1; wdata = 32'h0000_ABCD;
    @(negedge clk);
    mtlo_we = 1'b0;
    total++; if ({hi, lo} !== {m_hi, 32'h0000_ABCD}) begin bad++; $display("FAIL mtlo idle got %h want %h", {hi, lo}, {m_hi, 32'h0000_ABCD}); end
    m_lo = 32'h0000_ABCD;
    // MTHI held through the whole RUN window must be dropped.
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd3; req_b = 32'd4;
    @(negedge clk);
    req_valid = 1'b0; mthi_we = 1'b1; wdata = 32'h0000_1234;
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      total++; if (hi !== m_hi) begin bad++; $display("FAIL mthi busy%0d hi got %h want %h", i, hi, m_hi); end
    end
    mthi_we = 1'b0;
    @(negedge clk);
    total++; if ({done, hi, lo} !== {1'b1, 32'd0, 32'd12}) begin bad++; $display("FAIL mthi busy final got %h want %h", {done, hi, lo}, {1'b1, 32'd0, 32'd12}); end
    req_valid = 1'b1; req_a = 32'd2; req_b = 32'd5; mtlo_we = 1'b1; wdata = 32'h0000_5555;
    @(negedge clk);
    req_valid = 1'b0; mtlo_we = 1'b0;
    total++; if ({busy, lo} !== {1'b1, 32'h0000_5555}) begin bad++; $display("FAIL req+mtlo early got %h want %h", {busy, lo}, {1'b1, 32'h0000_5555}); end
    repeat (LAT - 1) @(negedge clk);
    @(negedge clk);
    total++; if ({done, hi, lo} !== {1'b1, 32'd0, 32'd10}) begin bad++; $display("FAIL req+mtlo final got %h want %h", {done, hi, lo}, {1'b1, 32'd0, 32'd10}); end
    mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000_CAFE;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    total++; if ({hi, lo} !== {32'h0000_CAFE, 32'h0000_CAFE}) begin bad++; $display("FAIL mthi+mtlo got %h want %h", {hi, lo}, {32'h0000_CAFE, 32'h0000_CAFE}); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b1; req_a = 32'hFFFF_FFFD; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({busy, done, mul_start, hi, lo, mul_in1, mul_in2} !== 131'd0) begin bad++; $display("FAIL reset mid got %h want 0", {busy, done, mul_start, hi, lo, mul_in1, mul_in2}); end
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      total++; if ({busy, done, hi, lo} !== 66'd0) begin bad++; $display("FAIL reset after%0d got %h want 0", i, {busy, done, hi, lo}); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_vector("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_mult_vector("mult_neg3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005,
                     32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    test_mult_vector("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000,
                     32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    test_mult_vector("mult_zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,
                     32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
    test_back_to_back();
    test_mt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Issue/writeback controller for the 32x32 unsigned multiplier array.
- Upstream, it accepts MULT/MULTU requests from the execute stage, converts signed operands to magnitudes, and drives the multiplier's start/in1/in2 inputs.
- Downstream, it samples the 64-bit product after a fixed latency, applies sign correction, and writes the architectural HI/LO registers.
- It also provides busy (pipeline stall), done, and MTHI/MTLO/MFHI/MFLO access.

Parameters:
- MULT_LATENCY, 4: clock cycles from operands presented with mul_start=1 until mul_out is valid. Legal range 1..15.
- WIDTH, 32: operand width. HI/LO are WIDTH each; the product is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  multiply request; accepted only in IDLE.
- req_signed  in  1  1=MULT (two's complement), 0=MULTU.
- req_a  in  WIDTH  multiplicand.
- req_b  in  WIDTH  multiplier.
- mthi_we  in  1  write wdata to HI.
- mtlo_we  in  1  write wdata to LO.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while a multiply is in flight; upstream stalls on it.
- done  out  1  one-cycle pulse the cycle after HI/LO are updated by a product.
- hi  out  WIDTH  HI register (MFHI source).
- lo  out  WIDTH  LO register (MFLO source).
- mul_start  out  1  start to multiplier.
- mul_in1  out  WIDTH  magnitude of a to multiplier.
- mul_in2  out  WIDTH  magnitude of b to multiplier.
- mul_out  in  2*WIDTH  unsigned product from multiplier.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE, cnt=0.
  - hi=0, lo=0, busy=0, done=0, mul_start=0, mul_in1=0, mul_in2=0, neg=0.
  - An in-flight product is discarded.
- States:
  - IDLE -> RUN on req_valid.
  - RUN -> IDLE when cnt==MULT_LATENCY-1.
- IDLE accept edge:
  - mul_in1 <= req_signed&req_a[WIDTH-1] ? -req_a : req_a; mul_in2 is formed the same way from req_b.
  - neg <= req_signed & (req_a[MSB]^req_b[MSB]).
  - mul_start <= 1, cnt <= 0, state <= RUN.
  - The magnitude of 0x80000000 is 0x80000000, which is a valid unsigned value.
- RUN:
  - mul_in1/mul_in2/mul_start are held stable every RUN cycle.
  - cnt increments each edge.
  - On the edge where cnt==MULT_LATENCY-1: p=mul_out; {hi,lo} <= neg ? (~p+1) : p (64-bit negate, carry across the LO/HI boundary); mul_start <= 0; state <= IDLE; done <= 1.
- Latency:
  - Request accepted at edge T; HI/LO are valid after edge T+MULT_LATENCY.
  - done is high for the cycle following edge T+MULT_LATENCY.
- busy = (state==RUN), combinational from the state register. It is low in the cycle done is high, so a back-to-back request is accepted that cycle.
- req_valid while busy is ignored; upstream must hold it.
- MTHI/MTLO:
  - Applied only in IDLE.
  - Dropped while busy, so HI/LO are not corrupted mid-operation.
  - If req_valid and mt*_we are high in the same IDLE cycle, both take effect: the MT write lands now and the product overwrites it later.
  - mthi_we and mtlo_we together write both registers.
- done is low whenever not on the completion edge.
- hi/lo are readable in every state. During RUN they show the previous values.

Decomposition:
- Shared package mdu_pkg:
  - state enum {IDLE, RUN}.
  - MULT_LATENCY default constant.
  - WIDTH constant.
  - Counter width derived as clog2(MULT_LATENCY).
- One natural sub-module: mult_sign_fix. It is combinational and provides two functions: WIDTH-bit conditional magnitude for operands, and 2*WIDTH conditional negate for the product. It is instantiated three times.

Test Plan:
- Bench multiplier model: a behavioral unsigned multiplier with a MULT_LATENCY-stage delay.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy for 4 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly once.
- MULT 0xFFFFFFFD(-3)*0x00000005 -> mul_in1=3, mul_in2=5; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT 0x80000000*0x80000000 -> mul_in1=mul_in2=0x80000000; hi=0x40000000, lo=0x00000000. Also MULT 0*0xFFFFFFFF -> hi=lo=0 (no negative zero).
- Back-to-back: second request (7*6 MULTU) held during busy and accepted the done cycle -> hi=0, lo=42 exactly 4 cycles later; no cycle lost.
- MTHI 0x1234 during RUN -> ignored, final hi from product. MTLO 0xABCD in IDLE -> lo=0xABCD next cycle.
- reset asserted at cnt==2 of a MULT -> next cycle all outputs 0, state IDLE, no done, HI/LO stay 0 after the latency elapses.
